// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared fetch buffer constants and the {pc,inst} entry type.
package fetch_buffer_pkg;
  localparam int FB_DEPTH = 8;
  localparam int FB_ENTRY_W = 64;
  localparam int FB_PTR_W = $clog2(FB_DEPTH);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fb_entry_t;
endpackage

// File: rtl/fetch_buffer_ram.sv
// fb_ram: DEPTH x 64 entry storage, two write ports, two combinational read ports (wa_1/wd_1, wa_2/wd_2 in; ra_1/ra_2 -> rd_1/rd_2).
import fetch_buffer_pkg::*;
module fb_ram #(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_1,
  input  logic [AW-1:0]   wa_1,
  input  fb_entry_t       wd_1,
  input  logic            we_2,
  input  logic [AW-1:0]   wa_2,
  input  fb_entry_t       wd_2,
  input  logic [AW-1:0]   ra_1,
  input  logic [AW-1:0]   ra_2,
  output fb_entry_t       rd_1,
  output fb_entry_t       rd_2
);
  fb_entry_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_1) mem[wa_1] <= wd_1;
    if (we_2) mem[wa_2] <= wd_2;
  end
  assign rd_1 = mem[ra_1];
  assign rd_2 = mem[ra_2];
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-issue circular {pc,inst} FIFO between fetch (if_*) and decode (id_*); optional fb_stall_cnt under FETCH_BUFFER_STALL_CNT_EN.
import fetch_buffer_pkg::*;
module fetch_buffer #(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid_1,
  input  logic        if_valid_2,
  input  logic [31:0] if_pc_1,
  input  logic [31:0] if_pc_2,
  input  logic [31:0] if_inst_1,
  input  logic [31:0] if_inst_2,
  output logic        fb_full,
  input  logic [1:0]  id_pop,
  output logic        id_valid_1,
  output logic        id_valid_2,
  output logic [31:0] id_pc_1,
  output logic [31:0] id_pc_2,
  output logic [31:0] id_inst_1,
  output logic [31:0] id_inst_2
`ifdef FETCH_BUFFER_STALL_CNT_EN
  ,
  output logic [31:0] fb_stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [1:0] push, pop_req, pop;
  fb_entry_t rd_1, rd_2;
  assign fb_full = (CW'(DEPTH) - count) < CW'(2);
  assign push = fb_full ? 2'd0 : {1'b0, if_valid_1} + {1'b0, if_valid_2};
  assign pop_req = id_pop == 2'd3 ? 2'd2 : id_pop;
  assign pop = CW'(pop_req) > count ? count[1:0] : pop_req;
  // Slot 1 of the ram always takes the first valid fetch slot, so a lone if_valid_2 lands at tail.
  fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we_1(push != 2'd0),
    .wa_1(tail),
    .wd_1(if_valid_1 ? {if_pc_1, if_inst_1} : {if_pc_2, if_inst_2}),
    .we_2(push == 2'd2),
    .wa_2(tail + AW'(1)),
    .wd_2({if_pc_2, if_inst_2}),
    .ra_1(head),
    .ra_2(head + AW'(1)),
    .rd_1(rd_1),
    .rd_2(rd_2)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(pop);
      tail <= tail + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign id_valid_1 = count >= CW'(1);
  assign id_valid_2 = count >= CW'(2);
  assign id_pc_1 = id_valid_1 ? rd_1.pc : '0;
  assign id_inst_1 = id_valid_1 ? rd_1.inst : '0;
  assign id_pc_2 = id_valid_2 ? rd_2.pc : '0;
  assign id_inst_2 = id_valid_2 ? rd_2.inst : '0;
`ifdef FETCH_BUFFER_STALL_CNT_EN
  // Counts fetch-blocked cycles; survives flush so redirects don't hide backpressure.
  always_ff @(posedge clk) begin
    if (rst) fb_stall_cnt <= '0;
    else if (fb_full && (if_valid_1 || if_valid_2)) fb_stall_cnt <= fb_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with a scoreboard queue checked by a decoupled monitor.
module tb_fetch_buffer;
  logic clk = 0, rst = 1, flush = 0;
  logic if_valid_1 = 0, if_valid_2 = 0;
  logic [31:0] if_pc_1 = 0, if_pc_2 = 0, if_inst_1 = 0, if_inst_2 = 0;
  logic [1:0] id_pop = 0;
  logic fb_full, id_valid_1, id_valid_2;
  logic [31:0] id_pc_1, id_pc_2, id_inst_1, id_inst_2;
`ifdef FETCH_BUFFER_STALL_CNT_EN
  logic [31:0] fb_stall_cnt;
`endif
  typedef struct {
    logic full, v1, v2;
    logic [31:0] pc1, pc2, stall;
    string name;
  } exp_t;
  exp_t q[$];
  int cmp = 0, errs = 0;
  logic cur_full = 0;
  logic [31:0] exp_stall = 0;
  always #5 clk = ~clk;
  fetch_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid_1(if_valid_1), .if_valid_2(if_valid_2),
    .if_pc_1(if_pc_1), .if_pc_2(if_pc_2), .if_inst_1(if_inst_1), .if_inst_2(if_inst_2),
    .fb_full(fb_full), .id_pop(id_pop),
    .id_valid_1(id_valid_1), .id_valid_2(id_valid_2),
    .id_pc_1(id_pc_1), .id_pc_2(id_pc_2), .id_inst_1(id_inst_1), .id_inst_2(id_inst_2)
`ifdef FETCH_BUFFER_STALL_CNT_EN
    , .fb_stall_cnt(fb_stall_cnt)
`endif
  );
  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "fb_full", 32'(fb_full), 32'(e.full));
      chk(e.name, "id_valid_1", 32'(id_valid_1), 32'(e.v1));
      chk(e.name, "id_valid_2", 32'(id_valid_2), 32'(e.v2));
      chk(e.name, "id_pc_1", id_pc_1, e.pc1);
      chk(e.name, "id_pc_2", id_pc_2, e.pc2);
      chk(e.name, "id_inst_1", id_inst_1, e.v1 ? ~e.pc1 : 32'h0);
      chk(e.name, "id_inst_2", id_inst_2, e.v2 ? ~e.pc2 : 32'h0);
`ifdef FETCH_BUFFER_STALL_CNT_EN
      chk(e.name, "fb_stall_cnt", fb_stall_cnt, e.stall);
`endif
    end
  end
  // Drives one cycle of inputs and queues the hand-computed state expected after that edge.
  task automatic step(input string n, input logic r, input logic f,
                      input logic v1, input logic [31:0] p1, input logic v2, input logic [31:0] p2,
                      input logic [1:0] pop,
                      input logic ef, input logic ev1, input logic ev2,
                      input logic [31:0] ep1, input logic [31:0] ep2);
    exp_t e;
    @(negedge clk);
    rst = r; flush = f; if_valid_1 = v1; if_valid_2 = v2;
    if_pc_1 = p1; if_pc_2 = p2; if_inst_1 = ~p1; if_inst_2 = ~p2; id_pop = pop;
    if (r) exp_stall = 0;
    else if (cur_full && (v1 || v2)) exp_stall++;
    cur_full = ef;
    e.name = n; e.full = ef; e.v1 = ev1; e.v2 = ev2; e.pc1 = ep1; e.pc2 = ep2; e.stall = exp_stall;
    q.push_back(e);
  endtask
  initial begin
    //    name        rst f  v1 pc1          v2 pc2          pop  full v1 v2 pc1          pc2
    step("reset",     1, 0, 0, 0,            0, 0,            0,   0, 0, 0, 0,            0);
    step("pair",      0, 0, 1, 32'hBFC00000, 1, 32'hBFC00004, 0,   0, 1, 1, 32'hBFC00000, 32'hBFC00004);
    step("pop2",      0, 0, 0, 0,            0, 0,            2,   0, 0, 0, 0,            0);
    step("fill2",     0, 0, 1, 32'hA0,       1, 32'hA4,       0,   0, 1, 1, 32'hA0,       32'hA4);
    step("fill4",     0, 0, 1, 32'hA8,       1, 32'hAC,       0,   0, 1, 1, 32'hA0,       32'hA4);
    step("fill6",     0, 0, 1, 32'hB0,       1, 32'hB4,       0,   0, 1, 1, 32'hA0,       32'hA4);
    step("fill8",     0, 0, 1, 32'hB8,       1, 32'hBC,       0,   1, 1, 1, 32'hA0,       32'hA4);
    step("drop8",     0, 0, 1, 32'hC0,       1, 32'hC4,       0,   1, 1, 1, 32'hA0,       32'hA4);
    step("pop1full",  0, 0, 1, 32'hC8,       1, 32'hCC,       1,   1, 1, 1, 32'hA4,       32'hA8);
    step("drop7",     0, 0, 1, 32'hC8,       1, 32'hCC,       0,   1, 1, 1, 32'hA4,       32'hA8);
    step("pop3",      0, 0, 0, 0,            0, 0,            3,   0, 1, 1, 32'hAC,       32'hB0);
    step("pushpop",   0, 0, 1, 32'hD0,       1, 32'hD4,       2,   0, 1, 1, 32'hB4,       32'hB8);
    step("wrap",      0, 0, 0, 0,            0, 0,            2,   0, 1, 1, 32'hBC,       32'hD0);
    step("pop_to1",   0, 0, 0, 0,            0, 0,            2,   0, 1, 0, 32'hD4,       0);
    step("clamp",     0, 0, 0, 0,            0, 0,            2,   0, 0, 0, 0,            0);
    step("f2",        0, 0, 1, 32'hE0,       1, 32'hE4,       0,   0, 1, 1, 32'hE0,       32'hE4);
    step("f4",        0, 0, 1, 32'hE8,       1, 32'hEC,       0,   0, 1, 1, 32'hE0,       32'hE4);
    step("f6",        0, 0, 1, 32'hF0,       1, 32'hF4,       0,   0, 1, 1, 32'hE0,       32'hE4);
    step("flush",     0, 1, 1, 32'hF8,       1, 32'hFC,       1,   0, 0, 0, 0,            0);
    step("lone2",     0, 0, 0, 32'h1234,     1, 32'h80000004, 0,   0, 1, 0, 32'h80000004, 0);
    step("more",      0, 0, 1, 32'h100,      1, 32'h104,      0,   0, 1, 1, 32'h80000004, 32'h100);
    step("rst_mid",   1, 0, 1, 32'h108,      1, 32'h10C,      1,   0, 0, 0, 0,            0);
    step("post_rst",  0, 0, 0, 0,            1, 32'h200,      0,   0, 1, 0, 32'h200,      0);
    @(negedge clk);
    rst = 0; if_valid_1 = 0; if_valid_2 = 0; id_pop = 0; flush = 0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    cmp++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of {pc,inst} entries; power of two, >= 4.
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have flush  input  1  discard all entries (branch mispredict/exception redirect).
REQ-005 SHALL have if_valid_1, if_valid_2  input  1 each  fetch slot valid.
REQ-006 SHALL have if_pc_1, if_pc_2, if_inst_1, if_inst_2  input  32 each  fetch slot PC and instruction word.
REQ-007 SHALL have fb_full  output  1  fewer than 2 free entries; fetch must stall.
REQ-008 SHALL have id_pop  input  2  entries consumed by decode this cycle (0, 1 or 2).
REQ-009 SHALL have id_valid_1, id_valid_2  output  1 each  head and head+1 entries valid.
REQ-010 SHALL have id_pc_1, id_pc_2, id_inst_1, id_inst_2  output  32 each  head and head+1 contents, feeding decode stage 1.

Function
REQ-011 SHALL be a circular FIFO with head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits).
REQ-012 SHALL compute push count as if_valid_1 + if_valid_2 and write valid slots compacted and in order at tail, tail+1 (slot 1 first; lone if_valid_2 goes to tail).
REQ-013 SHALL ignore all pushes in a cycle where fb_full is 1.
REQ-014 SHALL drive fb_full = (DEPTH - count < 2), from registered count only (no combinational path from inputs).
REQ-015 SHALL clamp effective pop to min(id_pop, count); id_pop = 3 treated as 2.
REQ-016 SHALL update count by push - effective pop in the same cycle; simultaneous push and pop both take effect.
REQ-017 SHALL drive id_valid_1 = (count >= 1), id_valid_2 = (count >= 2).
REQ-018 SHALL drive id_pc_x/id_inst_x to 0 when corresponding id_valid_x is 0.
REQ-019 SHALL make an entry pushed at edge N visible on outputs after edge N+1 (one-cycle latency, no bypass).
REQ-020 SHALL, on flush, reset head, tail, count to 0 at next edge; flush has priority over same-cycle push and pop.
REQ-021 SHALL never overwrite unpopped entries; pointer wrap from DEPTH-1 to 0 SHALL be seamless for both slots.

Reset
REQ-022 SHALL, with rst high at an edge, set head, tail, count = 0, so fb_full = 0, id_valid_1/2 = 0, all id_* data = 0.
REQ-023 SHALL give rst priority over flush, push and pop; reset mid-stream discards all entries.
REQ-024 SHALL not require storage array to be reset.

Configuration
REQ-025 SHALL support macro FETCH_BUFFER_STALL_CNT_EN.
REQ-026 SHALL, when defined, add output fb_stall_cnt (32 bits), incremented each cycle fb_full = 1 and any if_valid_x = 1, cleared by rst, not by flush, wraps at 2^32.
REQ-027 SHALL, when undefined, omit fb_stall_cnt port and counter logic; all other behaviour identical.

Structure
REQ-028 SHALL place DEPTH default, entry width (64) and pointer width constants in shared header fb_def.v, included like id_def.v.
REQ-029 SHALL implement storage as sub-module fb_ram: DEPTH x 64 register array, 2 write ports, 2 combinational read ports; pointer/count logic stays in fetch_buffer.

Verification
REQ-030 SHALL cover: reset, push pc 0xBFC00000/0xBFC00004 both valid -> next cycle id_valid_1 = id_valid_2 = 1, id_pc_1 = 0xBFC00000, id_pc_2 = 0xBFC00004.
REQ-031 SHALL cover: push 2/cycle, no pop, DEPTH = 8 -> fb_full = 1 after count reaches 7; further pushes dropped; count stays 8 at most.
REQ-032 SHALL cover: count = 1, id_pop = 2 -> one entry removed, count = 0, id_valid_1 = 0, outputs 0.
REQ-033 SHALL cover: count = 5, push 2 and pop 2 same cycle -> count = 5, order preserved across pointer wrap.
REQ-034 SHALL cover: count = 6, flush with push 2 same cycle -> count = 0, id_valid_1 = 0 next cycle; stall counter (if FETCH_BUFFER_STALL_CNT_EN) unchanged by flush.
REQ-035 SHALL cover: lone if_valid_2 with pc 0x80000004 into empty buffer -> id_pc_1 = 0x80000004, id_valid_2 = 0.
